// File: rtl/mult32_sequencer.sv
// rtl/mult32_sequencer.sv - sequential signed/unsigned shift-add multiplier with Kogge-Stone slice adder
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             request one multiplication (sampled in IDLE only)
//   in0, in1          multiplicand / multiplier, captured at accept
//   sign_en_in0/in1   1 = operand is two's complement, 0 = unsigned
//   busy              high in RUN and FIX
//   done              one-cycle pulse in DONE, result valid
//   result            2*WIDTH-bit product, held until the next FIX write

module cla4_ks (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g, p, g1, p1, g2, p2;
    logic [4:0] c;

    // Two prefix levels (span 1, span 2) give group generate/propagate for bits [i:0].
    always_comb begin
        g     = a & b;
        p     = a ^ b;
        g1[0] = g[0];
        p1[0] = p[0];
        for (int i = 1; i < 4; i++) begin
            g1[i] = g[i] | (p[i] & g[i-1]);
            p1[i] = p[i] & p[i-1];
        end
        for (int i = 0; i < 2; i++) begin
            g2[i] = g1[i];
            p2[i] = p1[i];
        end
        for (int i = 2; i < 4; i++) begin
            g2[i] = g1[i] | (p1[i] & g1[i-2]);
            p2[i] = p1[i] & p1[i-2];
        end
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            c[i+1] = g2[i] | (p2[i] & cin);
        end
        sum  = p ^ c[3:0];
        cout = c[4];
    end
endmodule

module mult32_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in0,
    input  logic [WIDTH-1:0]     in1,
    input  logic                 sign_en_in0,
    input  logic                 sign_en_in1,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);
    localparam int CW     = $clog2(WIDTH);
    localparam int SLICES = WIDTH / 4;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t               state, state_next;
    logic [CW-1:0]        iter;
    logic [WIDTH-1:0]     mag0, mag1;
    logic                 neg;
    logic [2*WIDTH-1:0]   acc;

    logic                 in0_neg, in1_neg;
    logic [WIDTH-1:0]     mag0_d, mag1_d;
    logic [WIDTH-1:0]     addend, sum;
    logic [SLICES:0]      carry;

    assign in0_neg = sign_en_in0 & in0[WIDTH-1];
    assign in1_neg = sign_en_in1 & in1[WIDTH-1];
    // The most-negative value negates to itself, which read unsigned is the correct magnitude.
    assign mag0_d  = in0_neg ? -in0 : in0;
    assign mag1_d  = in1_neg ? -in1 : in1;

    assign addend   = acc[0] ? mag0 : '0;
    assign carry[0] = 1'b0;

    for (genvar k = 0; k < SLICES; k++) begin : g_slice
        cla4_ks u_cla (
            .a    (acc[WIDTH + 4*k +: 4]),
            .b    (addend[4*k +: 4]),
            .cin  (carry[k]),
            .sum  (sum[4*k +: 4]),
            .cout (carry[k+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (iter == CW'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter   <= '0;
            mag0   <= '0;
            mag1   <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mag0 <= mag0_d;
                        mag1 <= mag1_d;
                        neg  <= in0_neg ^ in1_neg;
                        acc  <= {{WIDTH{1'b0}}, mag1_d};
                        iter <= '0;
                    end
                end
                RUN: begin
                    // Carry out of the top slice becomes the new MSB after the right shift.
                    acc  <= {carry[SLICES], sum, acc[WIDTH-1:1]};
                    iter <= iter + CW'(1);
                end
                FIX: begin
                    result <= neg ? -acc : acc;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN) || (state == FIX);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mult32_sequencer.sv
// tb/tb_mult32_sequencer.sv - self-checking bench for mult32_sequencer
module tb_mult32_sequencer;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  in0, in1;
    logic          sign_en_in0, sign_en_in1;
    logic          busy, done;
    logic [2*W-1:0] result;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] last_result;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           s0;
        logic           s1;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs[10];

    mult32_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in0         (in0),
        .in1         (in1),
        .sign_en_in0 (sign_en_in0),
        .sign_en_in1 (sign_en_in1),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s0, input logic s1);
        logic [2*W-1:0] x;
        logic [2*W-1:0] y;
        x = s0 ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        y = s1 ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return x * y;
    endfunction

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_mult(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s0, input logic s1, input logic [2*W-1:0] exp);
        int done_cnt;
        int timing_bad;
        logic [2*W-1:0] at_done;
        done_cnt   = 0;
        timing_bad = 0;
        at_done    = '0;
        @(negedge clk);
        in0 = a; in1 = b; sign_en_in0 = s0; sign_en_in1 = s1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({name, "_hold_at_accept"}, result, last_result);
        if (busy !== 1'b1 || done !== 1'b0) timing_bad++;
        for (int k = 1; k <= W + 2; k++) begin
            @(negedge clk);
            in0 = $urandom; in1 = $urandom;
            sign_en_in0 = 1'($urandom); sign_en_in1 = 1'($urandom);
            @(posedge clk);
            #1;
            if (busy !== (k <= W) || done !== (k == W + 1)) timing_bad++;
            if (done === 1'b1) done_cnt++;
            if (k == W + 1) at_done = result;
        end
        check({name, "_timing"}, 64'(timing_bad), 64'd0);
        check({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({name, "_result"}, at_done, exp);
        check({name, "_result_held"}, result, exp);
        last_result = exp;
    endtask

    initial begin
        int done_cnt;
        int timing_bad;
        logic [2*W-1:0] at_done;
        logic [W-1:0] ra, rb;
        logic rs0, rs1;

        rst = 1'b1; start = 1'b0; in0 = '0; in1 = '0;
        sign_en_in0 = 1'b0; sign_en_in1 = 1'b0;
        last_result = '0;

        vecs[0] = '{32'd3,         32'd5,         1'b0, 1'b0, 64'h0000_0000_0000_000F};
        vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 1'b0, 64'hFFFFFFFE_00000001};
        vecs[2] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 1'b1, 64'h0000_0000_0000_0001};
        vecs[3] = '{32'hFFFFFFF9,  32'd6,         1'b1, 1'b0, 64'hFFFFFFFF_FFFFFFD6};
        vecs[4] = '{32'h80000000,  32'h80000000,  1'b1, 1'b1, 64'h40000000_00000000};
        vecs[5] = '{32'h80000000,  32'h80000000,  1'b1, 1'b0, 64'hC0000000_00000000};
        vecs[6] = '{32'd0,         32'hFFFFFFFF,  1'b1, 1'b1, 64'h0000_0000_0000_0000};
        vecs[7] = '{32'h7FFFFFFF,  32'h80000000,  1'b1, 1'b1, 64'hC0000000_80000000};
        vecs[8] = '{32'd1,         32'h80000000,  1'b0, 1'b1, 64'hFFFFFFFF_80000000};
        vecs[9] = '{32'hFFFFFFFF,  32'd1,         1'b0, 1'b1, 64'h00000000_FFFFFFFF};

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_mult($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s0, vecs[i].s1, vecs[i].exp);
        end

        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = $urandom;
            if (i % 8 == 1) ra = 32'h80000000;
            if (i % 8 == 2) rb = 32'hFFFFFFFF;
            if (i % 8 == 3) rb = 32'd0;
            rs0 = 1'($urandom); rs1 = 1'($urandom);
            do_mult($sformatf("rand%0d", i), ra, rb, rs0, rs1, model(ra, rb, rs0, rs1));
        end

        // Second start held high during RUN must wait for IDLE after DONE.
        done_cnt = 0; timing_bad = 0; at_done = '0;
        @(negedge clk);
        in0 = 32'd2; in1 = 32'd3; sign_en_in0 = 1'b0; sign_en_in1 = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= W + 2; k++) begin
            @(negedge clk);
            if (k == 5) begin
                in0 = 32'd9; in1 = 32'd9; start = 1'b1;
            end
            @(posedge clk);
            #1;
            if (busy !== (k <= W) || done !== (k == W + 1)) timing_bad++;
            if (done === 1'b1) done_cnt++;
            if (k == W + 1) at_done = result;
        end
        check("overlap_timing", 64'(timing_bad), 64'd0);
        check("overlap_done_pulses", 64'(done_cnt), 64'd1);
        check("overlap_first_result", at_done, 64'd6);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("overlap_second_accepted", 64'(busy), 64'd1);
        check("overlap_result_not_cleared", result, 64'd6);
        done_cnt = 0; timing_bad = 0;
        for (int k = 1; k <= W + 1; k++) begin
            @(posedge clk);
            #1;
            if (busy !== (k <= W) || done !== (k == W + 1)) timing_bad++;
            if (done === 1'b1) done_cnt++;
        end
        check("overlap_second_timing", 64'(timing_bad), 64'd0);
        check("overlap_second_done", 64'(done_cnt), 64'd1);
        check("overlap_second_result", result, 64'd81);
        last_result = 64'd81;
        @(posedge clk);
        #1;

        // Asynchronous reset mid-RUN.
        @(negedge clk);
        in0 = 32'd100; in1 = 32'd200; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrun_rst_busy", 64'(busy), 64'd0);
        check("midrun_rst_done", 64'(done), 64'd0);
        check("midrun_rst_result", result, 64'd0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check("start_ignored_in_rst", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < W + 4; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) done_cnt++;
        end
        check("no_activity_after_rst", 64'(done_cnt), 64'd0);
        last_result = '0;
        do_mult("post_rst_4x4", 32'd4, 32'd4, 1'b0, 1'b0, 64'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
